// File: rtl/pacman_dir_arbiter_if.sv
// Keyboard and turn-evaluation signals between the pacman core and the direction arbiter.
// The arbiter uses the slave modport; the driving side uses the master modport.
interface pacman_dir_arbiter_if;
  logic [7:0] keycode;
  logic       keystrobe;
  logic       frame_tick;
  logic       aligned;
  logic [3:0] neighbour_open;
  logic [1:0] dir;
  logic       moving;
  logic       pending_valid;

  modport master (
    output keycode, frame_tick, aligned, neighbour_open,
    input  keystrobe, dir, moving, pending_valid
  );

  modport slave (
    input  keycode, frame_tick, aligned, neighbour_open,
    output keystrobe, dir, moving, pending_valid
  );
endinterface

// File: rtl/pacman_dir_arbiter.sv
// Buffers keyboard direction requests and applies them to pacman's heading on frame ticks.
// A request is taken at once if it reverses the heading, otherwise when the sprite is aligned.
module pacman_dir_arbiter #(
  parameter int HOLD_FRAMES = 8,
  parameter int ACK_CYCLES  = 1
) (
  input logic                  clk,
  input logic                  reset,
  pacman_dir_arbiter_if.slave  bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACK     = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam logic [3:0] ACK_LEN  = 4'(ACK_CYCLES);
  localparam logic [7:0] HOLD_LEN = 8'(HOLD_FRAMES);

  logic [1:0] state_r;
  logic [3:0] ack_cnt_r;
  logic       keystrobe_r;
  logic [1:0] pending_r;
  logic       pending_valid_r;
  logic [7:0] age_r;
  logic [1:0] dir_r;
  logic       moving_r;

  logic       key_valid_s;
  logic [1:0] key_dir_s;
  logic       accept_s;
  logic       reverse_s;
  logic       consume_s;
  logic [1:0] new_dir_s;
  logic [7:0] age_inc_s;

  // Keycode decode; unknown codes are acknowledged but never buffered.
  always_comb begin
    key_dir_s   = 2'd0;
    key_valid_s = 1'b0;
    case (bus.keycode)
      8'hf7: begin key_dir_s = 2'd0; key_valid_s = 1'b1; end
      8'he1: begin key_dir_s = 2'd1; key_valid_s = 1'b1; end
      8'hf3: begin key_dir_s = 2'd2; key_valid_s = 1'b1; end
      8'he4: begin key_dir_s = 2'd3; key_valid_s = 1'b1; end
      default: begin key_dir_s = 2'd0; key_valid_s = 1'b0; end
    endcase
  end

  // Turn decision from the registered pending/dir values seen at this edge.
  always_comb begin
    accept_s  = (state_r == ST_IDLE) && bus.keycode[7];
    reverse_s = (pending_r == (dir_r ^ 2'd2));
    consume_s = bus.frame_tick && pending_valid_r &&
                (reverse_s || (bus.aligned && bus.neighbour_open[pending_r]));
    if (consume_s) begin
      new_dir_s = pending_r;
    end else begin
      new_dir_s = dir_r;
    end
    if (age_r == 8'hff) begin
      age_inc_s = age_r;
    end else begin
      age_inc_s = age_r + 8'd1;
    end
  end

  // Key handshake: accept once, strobe for ACK_CYCLES, then wait for key release.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      ack_cnt_r   <= 4'd0;
      keystrobe_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.keycode[7]) begin
            state_r     <= ST_ACK;
            ack_cnt_r   <= 4'd1;
            keystrobe_r <= 1'b1;
          end else begin
            keystrobe_r <= 1'b0;
          end
        end
        ST_ACK: begin
          if (ack_cnt_r >= ACK_LEN) begin
            state_r     <= ST_RELEASE;
            keystrobe_r <= 1'b0;
          end else begin
            ack_cnt_r   <= ack_cnt_r + 4'd1;
            keystrobe_r <= 1'b1;
          end
        end
        ST_RELEASE: begin
          keystrobe_r <= 1'b0;
          if (!bus.keycode[7]) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          keystrobe_r <= 1'b0;
        end
      endcase
    end
  end

  // Heading, movement and request buffer; a coinciding key accept overrides the tick result.
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_r           <= 2'd1;
      moving_r        <= 1'b0;
      pending_r       <= 2'd0;
      pending_valid_r <= 1'b0;
      age_r           <= 8'd0;
    end else begin
      if (bus.frame_tick) begin
        dir_r    <= new_dir_s;
        moving_r <= !bus.aligned || bus.neighbour_open[new_dir_s];
        if (consume_s) begin
          pending_valid_r <= 1'b0;
        end else begin
          age_r <= age_inc_s;
          if (age_inc_s >= HOLD_LEN) begin
            pending_valid_r <= 1'b0;
          end
        end
      end
      if (accept_s && key_valid_s) begin
        pending_r       <= key_dir_s;
        pending_valid_r <= 1'b1;
        age_r           <= 8'd0;
      end
    end
  end

  assign bus.keystrobe     = keystrobe_r;
  assign bus.dir           = dir_r;
  assign bus.moving        = moving_r;
  assign bus.pending_valid = pending_valid_r;

endmodule

// File: tb/tb_pacman_dir_arbiter.sv
// Directed bench for pacman_dir_arbiter: a per-cycle vector table plus hand-written
// sequences for held keys, key/tick coincidence and reset during a long acknowledge.
module tb_pacman_dir_arbiter;

  logic clk;
  logic rst1;
  logic rst2;
  int   errors;
  int   checks;

  pacman_dir_arbiter_if b1 ();
  pacman_dir_arbiter_if b2 ();

  pacman_dir_arbiter #(.HOLD_FRAMES(8), .ACK_CYCLES(1)) dut1 (
    .clk   (clk),
    .reset (rst1),
    .bus   (b1)
  );

  pacman_dir_arbiter #(.HOLD_FRAMES(8), .ACK_CYCLES(4)) dut2 (
    .clk   (clk),
    .reset (rst2),
    .bus   (b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] kc;
    logic       tick;
    logic       al;
    logic [3:0] nopen;
    logic [1:0] e_dir;
    logic       e_mov;
    logic       e_pv;
    logic       e_ks;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic rst, input logic [7:0] kc, input logic tick, input logic al,
                     input logic [3:0] nopen, input logic [1:0] e_dir, input logic e_mov,
                     input logic e_pv, input logic e_ks);
    vec_t v;
    v.rst = rst; v.kc = kc; v.tick = tick; v.al = al; v.nopen = nopen;
    v.e_dir = e_dir; v.e_mov = e_mov; v.e_pv = e_pv; v.e_ks = e_ks;
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive1(input logic rst, input logic [7:0] kc, input logic tick,
                        input logic al, input logic [3:0] nopen);
    @(negedge clk);
    rst1 = rst; b1.keycode = kc; b1.frame_tick = tick; b1.aligned = al; b1.neighbour_open = nopen;
    @(posedge clk);
    #1;
  endtask

  task automatic drive2(input logic rst, input logic [7:0] kc);
    @(negedge clk);
    rst2 = rst; b2.keycode = kc; b2.frame_tick = 1'b0; b2.aligned = 1'b0; b2.neighbour_open = 4'b0000;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ks_cnt;
    errors = 0;
    checks = 0;
    rst1 = 1'b1; rst2 = 1'b1;
    b1.keycode = 8'h00; b1.frame_tick = 1'b0; b1.aligned = 1'b0; b1.neighbour_open = 4'b0000;
    b2.keycode = 8'h00; b2.frame_tick = 1'b0; b2.aligned = 1'b0; b2.neighbour_open = 4'b0000;

    //  rst   kc     tick  al    nopen    dir   mov   pv    ks
    add(1'b1, 8'h00, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'he4, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b1, 1'b1, 1'b1);
    add(1'b0, 8'he4, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b1, 1'b1, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 4'b0000, 2'd3, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h00, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'hf3, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b1, 1'b1);
    add(1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      add(1'b0, 8'h00, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'he1, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b1, 1'b1, 1'b1);
    add(1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++)
      add(1'b0, 8'h00, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'hf3, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b1, 1'b1, 1'b1);
    add(1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b1, 1'b1, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 4'b0000, 2'd2, 1'b1, 1'b1, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h85, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b1);
    add(1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0);

    foreach (vt[i]) begin
      drive1(vt[i].rst, vt[i].kc, vt[i].tick, vt[i].al, vt[i].nopen);
      chk($sformatf("v%0d dir", i), {6'd0, b1.dir}, {6'd0, vt[i].e_dir});
      chk($sformatf("v%0d moving", i), {7'd0, b1.moving}, {7'd0, vt[i].e_mov});
      chk($sformatf("v%0d pending_valid", i), {7'd0, b1.pending_valid}, {7'd0, vt[i].e_pv});
      chk($sformatf("v%0d keystrobe", i), {7'd0, b1.keystrobe}, {7'd0, vt[i].e_ks});
    end

    // Held key: one strobe, one acceptance of direction 0.
    drive1(1'b1, 8'h00, 1'b0, 1'b0, 4'b0000);
    ks_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      drive1(1'b0, 8'hf7, 1'b0, 1'b0, 4'b0000);
      if (b1.keystrobe === 1'b1) ks_cnt++;
    end
    chk("held strobe count", 8'(ks_cnt), 8'd1);
    chk("held pending_valid", {7'd0, b1.pending_valid}, 8'd1);
    drive1(1'b0, 8'h00, 1'b0, 1'b0, 4'b0000);
    chk("release no strobe", {7'd0, b1.keystrobe}, 8'd0);
    drive1(1'b0, 8'h00, 1'b1, 1'b1, 4'b0001);
    chk("held dir applied", {6'd0, b1.dir}, 8'd0);
    chk("held pv cleared", {7'd0, b1.pending_valid}, 8'd0);

    // Key accept coinciding with a tick: old request applied, new one buffered.
    drive1(1'b0, 8'he1, 1'b0, 1'b0, 4'b0000);
    drive1(1'b0, 8'h00, 1'b0, 1'b0, 4'b0000);
    drive1(1'b0, 8'h00, 1'b0, 1'b0, 4'b0000);
    drive1(1'b0, 8'he4, 1'b1, 1'b1, 4'b0010);
    chk("coinc dir", {6'd0, b1.dir}, 8'd1);
    chk("coinc pv", {7'd0, b1.pending_valid}, 8'd1);
    chk("coinc strobe", {7'd0, b1.keystrobe}, 8'd1);
    drive1(1'b0, 8'h00, 1'b1, 1'b0, 4'b0000);
    chk("coinc reverse dir", {6'd0, b1.dir}, 8'd3);
    chk("coinc reverse pv", {7'd0, b1.pending_valid}, 8'd0);

    // Reset in the middle of a 4-cycle acknowledge, key still held afterwards.
    drive2(1'b1, 8'h00);
    drive2(1'b0, 8'hf7);
    chk("ack4 strobe", {7'd0, b2.keystrobe}, 8'd1);
    drive2(1'b0, 8'hf7);
    chk("ack4 strobe 2", {7'd0, b2.keystrobe}, 8'd1);
    drive2(1'b1, 8'hf7);
    chk("mid-ack reset strobe", {7'd0, b2.keystrobe}, 8'd0);
    chk("mid-ack reset dir", {6'd0, b2.dir}, 8'd1);
    chk("mid-ack reset pv", {7'd0, b2.pending_valid}, 8'd0);
    ks_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      drive2(1'b0, 8'hf7);
      if (b2.keystrobe === 1'b1) ks_cnt++;
    end
    chk("reaccept strobe count", 8'(ks_cnt), 8'd4);
    chk("reaccept pv", {7'd0, b2.pending_valid}, 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
